// File: rtl/sram_1rw1r_param_clr.sv
// 1RW + 1R synchronous SRAM with per-lane write mask, hardware clear engine,
// selectable port-1 read-during-write bypass and a same-address collision flag.
module sram_1rw1r_param_clr #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 9,
    parameter int                    WMASK_WIDTH    = 8,
    parameter bit                    BYPASS         = 1'b1,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = {DATA_WIDTH{1'b0}},
    localparam int                   NUM_WMASKS     = DATA_WIDTH / WMASK_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    input  logic                  clear_req,
    output logic                  init_busy,
    output logic                  collision
);

    localparam int DEPTH = 32'sd1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] cnt_t;
    localparam cnt_t CNT_ZERO = {(ADDR_WIDTH + 1){1'b0}};
    localparam cnt_t CNT_ONE  = cnt_t'(32'sd1);
    localparam cnt_t CNT_LAST = cnt_t'(DEPTH - 32'sd1);
    localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    // Replace the masked lanes of old_word with the matching lanes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_WMASKS-1:0] mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (mask[i]) begin
                res[i*WMASK_WIDTH +: WMASK_WIDTH] = new_word[i*WMASK_WIDTH +: WMASK_WIDTH];
            end else begin
                res[i*WMASK_WIDTH +: WMASK_WIDTH] = old_word[i*WMASK_WIDTH +: WMASK_WIDTH];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    state_e                state_r;
    state_e                state_s;
    cnt_t                  cnt_r;
    cnt_t                  cnt_s;
    logic [DATA_WIDTH-1:0] dout0_r;
    logic [DATA_WIDTH-1:0] dout1_r;
    logic                  busy_r;
    logic                  coll_r;

    logic                  idle_s;
    logic                  wr_s;
    logic                  rd0_s;
    logic                  rd1_s;
    logic                  coll_s;
    logic                  clr_we_s;
    logic [DATA_WIDTH-1:0] rd1_word_s;

    // Port decode: requests are honoured only while the clear engine is idle.
    always_comb begin
        idle_s   = (state_r == ST_IDLE);
        clr_we_s = (state_r == ST_CLEAR);
        wr_s     = idle_s && !csb0 && !web0;
        rd0_s    = idle_s && !csb0 && web0;
        rd1_s    = idle_s && !csb1;
        coll_s   = wr_s && !csb1 && (addr0 == addr1);
        if (coll_s && BYPASS) begin
            rd1_word_s = merge_lanes(mem_r[addr1], din0, wmask0);
        end else begin
            rd1_word_s = mem_r[addr1];
        end
    end

    // Clear-engine next state; the counter is one bit wider than the address
    // so the terminal compare never depends on wrap-around.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    state_s = ST_CLEAR;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = cnt_r;
                end
            end
            ST_CLEAR: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = ST_CLEAR;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Array storage: no reset, written by the clear engine or by masked port-0 writes.
    always_ff @(posedge clk0) begin
        if (clr_we_s) begin
            mem_r[cnt_r[ADDR_WIDTH-1:0]] <= CLEAR_VALUE;
        end else if (wr_s) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    mem_r[addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= din0[i*WMASK_WIDTH +: WMASK_WIDTH];
                end
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_r <= RESET_STATE;
            cnt_r   <= CNT_ZERO;
            busy_r  <= CLEAR_ON_RESET;
            coll_r  <= 1'b0;
            dout0_r <= WORD_ZERO;
            dout1_r <= WORD_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s == ST_CLEAR);
            coll_r  <= coll_s;
            if (rd0_s) begin
                dout0_r <= mem_r[addr0];
            end
            if (rd1_s) begin
                dout1_r <= rd1_word_s;
            end
        end
    end

    assign dout0     = dout0_r;
    assign dout1     = dout1_r;
    assign init_busy = busy_r;
    assign collision = coll_r;

endmodule

// File: tb/tb_sram_1rw1r_param_clr.sv
// Scoreboard bench: instance 0 uses default parameters, instance 1 is the
// 64-bit / 16-bit-lane / 16-deep variant with old-data read and no auto-clear.
module tb_sram_1rw1r_param_clr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        csb0_v [2];
    logic        web0_v [2];
    logic [3:0]  wm_v   [2];
    logic [8:0]  a0_v   [2];
    logic [63:0] din_v  [2];
    logic        csb1_v [2];
    logic [8:0]  a1_v   [2];
    logic        clr_v  [2];

    logic [31:0] a_dout0, a_dout1;
    logic        a_busy, a_coll;
    logic [63:0] b_dout0, b_dout1;
    logic        b_busy, b_coll;

    sram_1rw1r_param_clr #(
        .DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(8),
        .BYPASS(1'b1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h0)
    ) u_a (
        .clk0(clk), .rst0_n(rst_n),
        .csb0(csb0_v[0]), .web0(web0_v[0]), .wmask0(wm_v[0]), .addr0(a0_v[0]),
        .din0(din_v[0][31:0]), .dout0(a_dout0),
        .csb1(csb1_v[0]), .addr1(a1_v[0]), .dout1(a_dout1),
        .clear_req(clr_v[0]), .init_busy(a_busy), .collision(a_coll)
    );

    sram_1rw1r_param_clr #(
        .DATA_WIDTH(64), .ADDR_WIDTH(4), .WMASK_WIDTH(16),
        .BYPASS(1'b0), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(64'h0)
    ) u_b (
        .clk0(clk), .rst0_n(rst_n),
        .csb0(csb0_v[1]), .web0(web0_v[1]), .wmask0(wm_v[1]), .addr0(a0_v[1][3:0]),
        .din0(din_v[1]), .dout0(b_dout0),
        .csb1(csb1_v[1]), .addr1(a1_v[1][3:0]), .dout1(b_dout1),
        .clear_req(clr_v[1]), .init_busy(b_busy), .collision(b_coll)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int depth_of(input int i); return (i == 0) ? 512 : 16; endfunction
    function automatic int dw_of(input int i);    return (i == 0) ? 32 : 64;  endfunction
    function automatic int lw_of(input int i);    return (i == 0) ? 8 : 16;   endfunction
    function automatic bit byp_of(input int i);   return (i == 0);            endfunction
    function automatic bit cor_of(input int i);   return (i == 0);            endfunction

    logic [63:0] m_mem [2][512];
    logic [63:0] m_d0 [2];
    logic [63:0] m_d1 [2];
    bit          m_coll [2];
    bit          m_busy [2];
    int          m_idx [2];

    typedef struct {
        int          inst;
        int          due;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        coll;
        logic        busy;
    } exp_t;
    exp_t sb_q [$];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_d0[i] = 64'h0; m_d1[i] = 64'h0; m_coll[i] = 1'b0;
            m_busy[i] = cor_of(i); m_idx[i] = 0;
        end
    endtask

    // Advance instance i by one clock using the inputs now applied.
    task automatic model_step(input int i);
        logic [63:0] old0, old1, merged;
        bit   wr;
        int   a0, a1;
        exp_t e;
        if (m_busy[i]) begin
            m_mem[i][m_idx[i]] = 64'h0;
            m_idx[i]++;
            if (m_idx[i] == depth_of(i)) m_busy[i] = 1'b0;
            m_coll[i] = 1'b0;
        end else begin
            a0 = int'(a0_v[i]) % depth_of(i);
            a1 = int'(a1_v[i]) % depth_of(i);
            wr = !csb0_v[i] && !web0_v[i];
            m_coll[i] = wr && !csb1_v[i] && (a0 == a1);
            old0 = m_mem[i][a0];
            old1 = m_mem[i][a1];
            merged = old0;
            for (int b = 0; b < dw_of(i); b++)
                if (wm_v[i][b / lw_of(i)]) merged[b] = din_v[i][b];
            if (!csb1_v[i]) m_d1[i] = (m_coll[i] && byp_of(i)) ? merged : old1;
            if (!csb0_v[i] && web0_v[i]) m_d0[i] = old0;
            if (wr) m_mem[i][a0] = merged;
            if (clr_v[i]) begin m_busy[i] = 1'b1; m_idx[i] = 0; end
        end
        e.inst = i; e.due = cyc + 1;
        e.d0 = m_d0[i]; e.d1 = m_d1[i]; e.coll = m_coll[i]; e.busy = m_busy[i];
        sb_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    exp_t cur;
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            cur = sb_q.pop_front();
            if (cur.due != cyc) check("sb_late", 64'(cur.due), 64'(cyc));
            if (cur.inst == 0) begin
                check($sformatf("a_dout0@%0d", cur.due), {32'h0, a_dout0}, cur.d0);
                check($sformatf("a_dout1@%0d", cur.due), {32'h0, a_dout1}, cur.d1);
                check($sformatf("a_coll@%0d", cur.due), 64'(a_coll), 64'(cur.coll));
                check($sformatf("a_busy@%0d", cur.due), 64'(a_busy), 64'(cur.busy));
            end else begin
                check($sformatf("b_dout0@%0d", cur.due), b_dout0, cur.d0);
                check($sformatf("b_dout1@%0d", cur.due), b_dout1, cur.d1);
                check($sformatf("b_coll@%0d", cur.due), 64'(b_coll), 64'(cur.coll));
                check($sformatf("b_busy@%0d", cur.due), 64'(b_busy), 64'(cur.busy));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_in(input int i);
        csb0_v[i] = 1'b1; web0_v[i] = 1'b1; wm_v[i] = 4'h0; a0_v[i] = 9'h0;
        din_v[i] = 64'h0; csb1_v[i] = 1'b1; a1_v[i] = 9'h0; clr_v[i] = 1'b0;
    endtask

    task automatic rand_in(input int i, input bit allow_clr);
        csb0_v[i] = ($urandom_range(0, 3) == 0);
        web0_v[i] = 1'($urandom_range(0, 1));
        wm_v[i]   = 4'($urandom_range(0, 15));
        a0_v[i]   = 9'($urandom_range(0, 15));
        if (i == 0 && $urandom_range(0, 3) == 0) a0_v[i] = 9'($urandom_range(0, 511));
        a1_v[i]   = ($urandom_range(0, 1) == 0) ? a0_v[i] : 9'($urandom_range(0, 15));
        csb1_v[i] = ($urandom_range(0, 3) == 0);
        din_v[i]  = {$urandom, $urandom};
        clr_v[i]  = allow_clr && ($urandom_range(0, 31) == 0);
    endtask

    task automatic wr(input int i, input int a, input logic [63:0] d, input logic [3:0] m);
        idle_in(i);
        csb0_v[i] = 1'b0; web0_v[i] = 1'b0; a0_v[i] = 9'(a); din_v[i] = d; wm_v[i] = m;
    endtask

    task automatic rd0(input int i, input int a);
        idle_in(i);
        csb0_v[i] = 1'b0; web0_v[i] = 1'b1; a0_v[i] = 9'(a);
    endtask

    task automatic rd1(input int i, input int a);
        csb1_v[i] = 1'b0; a1_v[i] = 9'(a);
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_a_dout0", {32'h0, a_dout0}, 64'h0);
        check("rst_a_dout1", {32'h0, a_dout1}, 64'h0);
        check("rst_a_coll", 64'(a_coll), 64'h0);
        check("rst_a_busy", 64'(a_busy), 64'h1);
        check("rst_b_busy", 64'(b_busy), 64'h0);
        check("rst_b_dout1", b_dout1, 64'h0);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int n;

    initial begin
        rst_n = 1'b1;
        idle_in(0);
        idle_in(1);
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 512; a++) m_mem[i][a] = 64'h0;
        @(posedge clk);
        #1;
        do_reset(3);

        // Power-up clear of instance 0; instance 1 is cleared on request.
        n = 0;
        do begin
            rand_in(0, 1'b1);
            if (n == 0) begin idle_in(1); clr_v[1] = 1'b1; end
            else rand_in(1, 1'b0);
            step();
            n++;
            if (n == 16) check("b_clear_busy16", 64'(b_busy), 64'h1);
            if (n == 17) check("b_clear_busy17", 64'(b_busy), 64'h0);
        end while (a_busy && n < 2000);
        check("a_reset_clear_len", 64'(n), 64'd512);

        idle_in(0); rd1(0, 5); idle_in(1);
        step();
        check("a_rd1_addr5", {32'h0, a_dout1}, 64'h0);

        // Masked writes on both widths.
        wr(0, 7, 64'h11223344, 4'b1111); wr(1, 3, 64'h0123456789ABCDEF, 4'b1111);
        step();
        wr(0, 7, 64'hAABBCCDD, 4'b0101); wr(1, 3, 64'hFFFFFFFFFFFFFFFF, 4'b1000);
        step();
        rd0(0, 7); rd0(1, 3);
        step();
        check("a_masked_rd", {32'h0, a_dout0}, 64'h11BB33DD);
        check("b_lane3_only", b_dout0, 64'hFFFF456789ABCDEF);

        // Collision: new data on instance 0, old data on instance 1.
        idle_in(0); wr(1, 9, 64'h0, 4'b1111);
        step();
        wr(0, 9, 64'hDEADBEEF, 4'b0011); rd1(0, 9);
        wr(1, 9, 64'hDEADBEEFDEADBEEF, 4'b0011); rd1(1, 9);
        step();
        check("a_coll_bypass", {32'h0, a_dout1}, 64'h0000BEEF);
        check("a_coll_flag", 64'(a_coll), 64'h1);
        check("b_coll_old", b_dout1, 64'h0);
        check("b_coll_flag", 64'(b_coll), 64'h1);
        idle_in(0); idle_in(1);
        step();
        check("a_coll_pulse", 64'(a_coll), 64'h0);
        check("b_coll_pulse", 64'(b_coll), 64'h0);

        // Deselected port 1 holds.
        idle_in(0); rd1(0, 7);
        step();
        for (int k = 0; k < 4; k++) begin
            idle_in(0); a1_v[0] = 9'($urandom_range(0, 511));
            step();
            check("a_dout1_hold", {32'h0, a_dout1}, 64'h11BB33DD);
        end

        // Clear requested from idle, with extra requests while busy.
        idle_in(0); clr_v[0] = 1'b1; idle_in(1);
        step();
        n = 0;
        do begin
            rand_in(0, 1'b1);
            rand_in(1, 1'b0);
            step();
            n++;
        end while (a_busy && n < 2000);
        check("a_idle_clear_len", 64'(n), 64'd512);
        rd0(0, 7); idle_in(1);
        step();
        check("a_addr7_cleared", {32'h0, a_dout0}, 64'h0);

        // Reset in the middle of both clear sequences.
        for (int a = 0; a < 16; a++) begin
            idle_in(0); wr(1, a, {$urandom, $urandom} | 64'h1, 4'b1111);
            step();
        end
        idle_in(0); clr_v[0] = 1'b1; idle_in(1);
        step();
        for (int k = 1; k <= 100; k++) begin
            rand_in(0, 1'b1);
            idle_in(1);
            if (k == 95) clr_v[1] = 1'b1;
            step();
        end
        do_reset(3);
        n = 0;
        do begin
            rand_in(0, 1'b1);
            idle_in(1);
            if (n < 16) begin
                rd1(1, n);
                csb0_v[1] = 1'b0; web0_v[1] = 1'b1; a0_v[1] = 9'(15 - n);
            end
            step();
            n++;
            if (n == 256) begin
                check("a_hold_d0_in_clear", {32'h0, a_dout0}, 64'h0);
                check("a_hold_d1_in_clear", {32'h0, a_dout1}, 64'h0);
            end
        end while (a_busy && n < 2000);
        check("a_restart_clear_len", 64'(n), 64'd512);

        // Free-running random traffic.
        for (int k = 0; k < 1500; k++) begin
            rand_in(0, $urandom_range(0, 15) == 0);
            rand_in(1, 1'b1);
            step();
        end
        idle_in(0); idle_in(1);
        @(negedge clk);
        #1;
        check("sb_drain", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
